ahb3lite_fifo_slave: RTL and testbench

- AHB3-Lite slave that serializes each bus transfer into a byte request stream on an outbound FIFO, then parses the byte response from an inbound FIFO.
- Implements the initiator end of the host byte protocol that ahb3lite_host_master executes. It lets on-chip masters tunnel AHB3 accesses over a byte transport: a FIFO pair feeding dual_clock_fifo / uart_fifo.
- Single clock domain; one outstanding transfer at a time.

---
 rtl/ahb3lite_fifo_slave.sv | 186 ++++++++++++++++++
 tb/tb_ahb3lite_fifo_slave.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_fifo_slave.sv
// ahb3lite_fifo_slave
//   AHB3-Lite slave that tunnels each bus transfer over a byte transport.
//   Every accepted beat is serialized into a request byte stream on an
//   outbound FIFO (cmd, 4 address bytes, write data) and completed by
//   parsing a response byte stream from an inbound FIFO (status, read data).
//   One transfer is outstanding at a time.
//
// Ports
//   CLK, RESETn          clock, asynchronous active-low reset
//   HSEL..HREADY         AHB3-Lite slave inputs (HBURST/HPROT ignored)
//   HRDATA/HRESP/HREADYOUT  AHB3-Lite slave outputs
//   WREN/WRFULL/WRDATA   outbound (request) FIFO write port
//   RDEN/RDEMPTY/RDDATA  inbound (response) FIFO read port, RDDATA valid
//                        the cycle after RDEN
//   SYNC_LOST            sticky: a response timeout desynchronized the link
module ahb3lite_fifo_slave #(
  parameter int TIMEOUT    = 4096,
  parameter int TCNT_WIDTH = 13
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        HREADYOUT,
  output logic        WREN,
  input  logic        WRFULL,
  output logic [7:0]  WRDATA,
  output logic        RDEN,
  input  logic        RDEMPTY,
  input  logic [7:0]  RDDATA,
  output logic        SYNC_LOST
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RSTAT, S_RDATA, S_DONE, S_ERR1, S_ERR2
  } state_t;

  // Count value at which the current wait has lasted TIMEOUT cycles.
  localparam logic [TCNT_WIDTH-1:0] TLIM =
    (TIMEOUT == 0) ? '0 : TCNT_WIDTH'(TIMEOUT - 1);

  state_t                r_state, w_state_next;
  logic [31:0]           r_addr;
  logic [1:0]            r_size;
  logic                  r_write;
  logic [31:0]           r_wdata;
  logic                  r_accept_d;
  logic [1:0]            r_bcnt;
  logic [TCNT_WIDTH-1:0] r_tcnt;
  logic                  r_rd_inflight;
  logic                  r_sync_lost;
  logic [31:0]           r_hrdata;

  logic       w_addr_phase_ok;
  logic       w_accept;
  logic       w_misalign;
  logic       w_local_err;
  logic       w_req_state;
  logic       w_rsp_state;
  logic       w_wait;
  logic       w_timeout;
  logic       w_rbyte;
  logic [1:0] w_nm1;
  logic [1:0] w_lane;
  logic       w_unused;

  assign w_unused = ^{HBURST, HPROT, HTRANS[0]};

  // An address phase completes whenever our HREADYOUT is high, so a
  // pipelined beat presented during DONE/ERR2 is taken as well as in IDLE.
  assign w_addr_phase_ok = (r_state == S_IDLE) || (r_state == S_DONE) ||
                           (r_state == S_ERR2);
  assign w_accept    = HSEL && HREADY && HTRANS[1] && w_addr_phase_ok;
  assign w_misalign  = ((HSIZE == 3'd1) && HADDR[0]) ||
                       ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign w_local_err = (HSIZE > 3'd2) || w_misalign || r_sync_lost;

  // Number of data bytes minus one: size 0/1/2 -> 0/1/3.
  assign w_nm1  = {r_size[1], |r_size};
  assign w_lane = r_addr[1:0] + r_bcnt;

  assign w_req_state = (r_state == S_CMD) || (r_state == S_ADDR) ||
                       (r_state == S_WDATA);
  assign w_rsp_state = (r_state == S_RSTAT) || (r_state == S_RDATA);

  assign WREN = w_req_state && !WRFULL;
  // Only one inbound read in flight: RDDATA is consumed before the next RDEN.
  assign RDEN = w_rsp_state && !RDEMPTY && !r_rd_inflight;

  assign w_wait    = w_rsp_state && !r_rd_inflight && RDEMPTY;
  assign w_timeout = (TIMEOUT != 0) && w_wait && (r_tcnt == TLIM);
  assign w_rbyte   = (r_state == S_RDATA) && r_rd_inflight;

  always_comb begin
    WRDATA = 8'h00;
    case (r_state)
      S_CMD:   WRDATA = {5'b0, r_write, r_size};
      S_ADDR:  WRDATA = r_addr[{r_bcnt, 3'b000} +: 8];
      S_WDATA: WRDATA = r_wdata[{w_lane, 3'b000} +: 8];
      default: WRDATA = 8'h00;
    endcase
  end

  assign HREADYOUT = (r_state == S_IDLE) || (r_state == S_DONE) ||
                     (r_state == S_ERR2);
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign HRDATA    = r_hrdata;
  assign SYNC_LOST = r_sync_lost;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        if (w_accept) w_state_next = w_local_err ? S_ERR1 : S_CMD;
        else          w_state_next = S_IDLE;
      end
      S_CMD:
        if (WREN) w_state_next = S_ADDR;
      S_ADDR:
        if (WREN && (r_bcnt == 2'd3)) w_state_next = r_write ? S_WDATA : S_RSTAT;
      S_WDATA:
        if (WREN && (r_bcnt == w_nm1)) w_state_next = S_RSTAT;
      S_RSTAT: begin
        if (w_timeout)                w_state_next = S_ERR1;
        else if (r_rd_inflight) begin
          if (RDDATA != 8'h00)        w_state_next = S_ERR1;
          else                        w_state_next = r_write ? S_DONE : S_RDATA;
        end
      end
      S_RDATA: begin
        if (w_timeout)                          w_state_next = S_ERR1;
        else if (w_rbyte && (r_bcnt == w_nm1))  w_state_next = S_DONE;
      end
      S_ERR1:  w_state_next = S_ERR2;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_addr        <= '0;
      r_size        <= '0;
      r_write       <= 1'b0;
      r_wdata       <= '0;
      r_accept_d    <= 1'b0;
      r_bcnt        <= '0;
      r_tcnt        <= '0;
      r_rd_inflight <= 1'b0;
      r_sync_lost   <= 1'b0;
      r_hrdata      <= '0;
    end else begin
      r_accept_d    <= w_accept;
      r_rd_inflight <= RDEN;
      if (w_accept) begin
        r_addr  <= HADDR;
        r_size  <= HSIZE[1:0];
        r_write <= HWRITE;
      end
      // HWDATA belongs to the first data-phase cycle.
      if (r_accept_d) r_wdata <= HWDATA;
      // Byte index restarts on every state change.
      if (w_state_next != r_state)  r_bcnt <= '0;
      else if (WREN || w_rbyte)     r_bcnt <= r_bcnt + 2'd1;
      if (w_rbyte) r_hrdata[{w_lane, 3'b000} +: 8] <= RDDATA;
      // Only response-side waits count; request stalls never time out.
      if (!w_rsp_state || r_rd_inflight) r_tcnt <= '0;
      else if (w_wait)                   r_tcnt <= r_tcnt + TCNT_WIDTH'(1);
      if (w_timeout) r_sync_lost <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb3lite_fifo_slave.sv
module tb_ahb3lite_fifo_slave;

  logic        CLK;
  logic        RESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        HREADYOUT;
  logic        WREN;
  logic        WRFULL;
  logic [7:0]  WRDATA;
  logic        RDEN;
  logic        RDEMPTY;
  logic [7:0]  RDDATA;
  logic        SYNC_LOST;

  ahb3lite_fifo_slave #(.TIMEOUT(16), .TCNT_WIDTH(5)) dut (
    .CLK(CLK), .RESETn(RESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWRITE(HWRITE), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
    .HREADYOUT(HREADYOUT), .WREN(WREN), .WRFULL(WRFULL), .WRDATA(WRDATA),
    .RDEN(RDEN), .RDEMPTY(RDEMPTY), .RDDATA(RDDATA), .SYNC_LOST(SYNC_LOST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  // Outbound FIFO model: log every byte written.
  logic [7:0] wr_log [0:255];
  int         wr_cnt = 0;
  int         wren_full_cnt = 0;
  always @(posedge CLK) begin
    if (WREN) begin
      wr_log[wr_cnt[7:0]] <= WRDATA;
      wr_cnt <= wr_cnt + 1;
      if (WRFULL) wren_full_cnt <= wren_full_cnt + 1;
    end
  end

  // Inbound FIFO model: bench pushes, DUT pops; RDDATA valid after RDEN.
  logic [7:0] rsp_mem [0:63];
  int         rsp_wr = 0;
  int         rsp_rd = 0;
  logic [5:0] rd_idx = '0;
  logic       drop_req;
  assign RDEMPTY = (rsp_rd == rsp_wr);
  assign RDDATA  = rsp_mem[rd_idx];
  always @(posedge CLK) begin
    if (drop_req) rsp_rd <= rsp_wr;
    else if (RDEN) begin
      rd_idx <= rsp_rd[5:0];
      rsp_rd <= rsp_rd + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_rsp(input logic [7:0] b);
    rsp_mem[rsp_wr[5:0]] = b;
    rsp_wr++;
  endtask

  task automatic drop_rsp();
    @(negedge CLK);
    drop_req = 1'b1;
    @(negedge CLK);
    drop_req = 1'b0;
  endtask

  // Request bytes are given in send order, packed first-byte-most-significant.
  task automatic check_req(input string tag, input int base, input int n, input logic [71:0] exp);
    check({tag, "_nbytes"}, wr_cnt - base, n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), wr_log[(base + i) % 256], exp[8*(n-1-i) +: 8]);
  endtask

  // One AHB beat. full_at/full_len: once full_at request bytes are out,
  // hold WRFULL for full_len cycles (full_len=0 disables).
  task automatic ahb_xfer(input logic [31:0] addr, input logic [2:0] size,
                          input logic wr, input logic [31:0] wdata,
                          input int full_at, input int full_len,
                          output int stalls, output int err_cycles,
                          output logic fin_resp, output logic [31:0] rdata);
    int  base;
    int  held;
    bit  full_done;
    bit  done;
    base = wr_cnt;
    held = 0;
    full_done = 0;
    done = 0;
    stalls = 0;
    err_cycles = 0;
    fin_resp = 1'b0;
    rdata = '0;
    @(negedge CLK);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HSIZE = size; HWRITE = wr;
    HWDATA = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (k == 1) HWDATA = ~wdata;
      if (HREADYOUT) begin
        fin_resp = HRESP;
        rdata = HRDATA;
        done = 1;
        break;
      end
      stalls++;
      if (HRESP) err_cycles++;
      if (full_len > 0 && !full_done) begin
        if (!WRFULL && (wr_cnt - base) == full_at) begin
          WRFULL = 1'b1;
          held = 0;
        end else if (WRFULL) begin
          held++;
          if (held == full_len) begin
            WRFULL = 1'b0;
            full_done = 1;
          end
        end
      end
    end
    WRFULL = 1'b0;
    check("xfer_done", done, 1);
    $display("xfer addr=%h size=%0d wr=%0b stalls=%0d errc=%0d resp=%0b hrdata=%h sync=%0b",
             addr, size, wr, stalls, err_cycles, fin_resp, rdata, SYNC_LOST);
  endtask

  int          st, ec, wb, rb;
  logic        rs;
  logic [31:0] rd;

  initial begin
    RESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HTRANS = 2'b00;
    HSIZE = '0; HBURST = '0; HPROT = '0; HWRITE = 1'b0; HREADY = 1'b1;
    WRFULL = 1'b0; drop_req = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_hrdata", HRDATA, 0);
    check("rst_hresp", HRESP, 0);
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_wren", WREN, 0);
    check("rst_wrdata", WRDATA, 0);
    check("rst_rden", RDEN, 0);
    check("rst_sync_lost", SYNC_LOST, 0);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);

    // Write word, OKAY: 9 request + RDEN + sample cycles stall, then DONE.
    push_rsp(8'h00);
    wb = wr_cnt; rb = rsp_rd;
    ahb_xfer(32'h2000_0010, 3'd2, 1'b1, 32'hDEAD_BEEF, 0, 0, st, ec, rs, rd);
    check_req("w32", wb, 9, {8'h06, 8'h10, 8'h00, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    check("w32_stalls", st, 11);
    check("w32_errc", ec, 0);
    check("w32_hresp", rs, 0);
    check("w32_consumed", rsp_rd - rb, 1);

    // Read byte at lane 3.
    push_rsp(8'h00); push_rsp(8'h5A);
    wb = wr_cnt; rb = rsp_rd;
    ahb_xfer(32'h4000_0003, 3'd0, 1'b0, 32'h0, 0, 0, st, ec, rs, rd);
    check_req("r8", wb, 5, {8'h00, 8'h03, 8'h00, 8'h00, 8'h40});
    check("r8_stalls", st, 9);
    check("r8_hresp", rs, 0);
    check("r8_hrdata", rd, 32'h5A00_0000);
    check("r8_consumed", rsp_rd - rb, 2);

    // Read word with error status: no data bytes consumed, ERR1 then ERR2.
    push_rsp(8'h01); push_rsp(8'hAA);
    wb = wr_cnt; rb = rsp_rd;
    ahb_xfer(32'h4000_0000, 3'd2, 1'b0, 32'h0, 0, 0, st, ec, rs, rd);
    check_req("r32e", wb, 5, {8'h02, 8'h00, 8'h00, 8'h00, 8'h40});
    check("r32e_stalls", st, 8);
    check("r32e_errc", ec, 1);
    check("r32e_hresp", rs, 1);
    check("r32e_consumed", rsp_rd - rb, 1);
    check("r32e_hrdata_kept", rd, 32'h5A00_0000);
    drop_rsp();

    // Misaligned halfword write: local error, no FIFO traffic.
    wb = wr_cnt;
    ahb_xfer(32'h0000_1001, 3'd1, 1'b1, 32'h1234_5678, 0, 0, st, ec, rs, rd);
    check("mis_wren", wr_cnt - wb, 0);
    check("mis_stalls", st, 1);
    check("mis_errc", ec, 1);
    check("mis_hresp", rs, 1);

    // Oversized transfer: local error.
    wb = wr_cnt;
    ahb_xfer(32'h0000_1000, 3'd3, 1'b0, 32'h0, 0, 0, st, ec, rs, rd);
    check("sz3_wren", wr_cnt - wb, 0);
    check("sz3_stalls", st, 1);
    check("sz3_hresp", rs, 1);

    // WRFULL held 20 cycles after cmd + 2 address bytes.
    push_rsp(8'h00);
    wb = wr_cnt;
    ahb_xfer(32'h3000_0004, 3'd2, 1'b1, 32'h0123_4567, 3, 20, st, ec, rs, rd);
    check_req("wfull", wb, 9, {8'h06, 8'h04, 8'h00, 8'h00, 8'h30, 8'h67, 8'h45, 8'h23, 8'h01});
    check("wfull_stalls", st, 31);
    check("wfull_hresp", rs, 0);
    check("wfull_no_wren_when_full", wren_full_cnt, 0);
    check("wfull_sync_lost", SYNC_LOST, 0);

    // Response never arrives: times out after 16 waiting cycles.
    rb = rsp_rd;
    ahb_xfer(32'h5000_0000, 3'd2, 1'b0, 32'h0, 0, 0, st, ec, rs, rd);
    check("tmo_stalls", st, 22);
    check("tmo_errc", ec, 1);
    check("tmo_hresp", rs, 1);
    check("tmo_sync_lost", SYNC_LOST, 1);
    check("tmo_consumed", rsp_rd - rb, 0);

    // While desynchronized every transfer fails locally.
    push_rsp(8'h00);
    wb = wr_cnt; rb = rsp_rd;
    ahb_xfer(32'h2000_0000, 3'd2, 1'b1, 32'hCAFE_F00D, 0, 0, st, ec, rs, rd);
    check("sl_wren", wr_cnt - wb, 0);
    check("sl_consumed", rsp_rd - rb, 0);
    check("sl_stalls", st, 1);
    check("sl_hresp", rs, 1);
    drop_rsp();

    // Reset pulse clears SYNC_LOST.
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    check("rst2_sync_lost", SYNC_LOST, 0);
    check("rst2_hreadyout", HREADYOUT, 1);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    // Halfword read at upper lanes after recovery.
    push_rsp(8'h00); push_rsp(8'h34); push_rsp(8'h12);
    wb = wr_cnt;
    ahb_xfer(32'h4000_0002, 3'd1, 1'b0, 32'h0, 0, 0, st, ec, rs, rd);
    check_req("r16", wb, 5, {8'h01, 8'h02, 8'h00, 8'h00, 8'h40});
    check("r16_stalls", st, 11);
    check("r16_hresp", rs, 0);
    check("r16_hrdata", rd, 32'h1234_0000);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
